// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel stage sequencer.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Slot phases at which each stage pulse is issued
  localparam int PH_POP   = 2;
  localparam int PH_SHIFT = 4;
  localparam int PH_HOLD  = 6;
  localparam int PH_MAG   = 8;

  // Input SRAM word-address width
  localparam int ADDR_W = 20;

endpackage

// File: rtl/sobel_slot_timer.sv
// Per-word slot phase counter. Counts 0..SLOT_LEN-1 while running, holds at
// phase 0 while holdOff is high, and flags the last phase of a slot.
module sobel_slot_timer #(
  parameter int SLOT_LEN = 12,
  parameter int PW       = $clog2(SLOT_LEN)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          run_i,
  input  logic          holdOff_i,
  output logic [PW-1:0] phase_o,
  output logic [PW-1:0] phase_d_o,
  output logic          wrap_o
);

  logic [PW-1:0] phase_q, phase_d;
  logic          stall;

  // Back-pressure only bites at slot start; wrap after the last phase
  always_comb begin
    stall   = run_i && (phase_q == '0) && holdOff_i;
    wrap_o  = run_i && !stall && (phase_q == PW'(SLOT_LEN - 1));
    phase_d = phase_q;
    if (!run_i || wrap_o) phase_d = '0;
    else if (!stall)      phase_d = phase_q + 1'b1;
  end

  // Phase register
  always_ff @(posedge clk_i) begin
    if (!reset_i) phase_q <= '0;
    else          phase_q <= phase_d;
  end

  assign phase_o   = phase_q;
  assign phase_d_o = phase_d;

endmodule

// File: rtl/sobel_stage_sequencer.sv
// Sobel stage sequencer: walks one frame of input words, issuing a fixed
// pattern of one-cycle stage pulses per word slot, an early refill request,
// and a frameDone pulse after the pipeline drains.
// Optional macro SOBEL_LINE_SKIP_EN: process alternate image lines only.
module sobel_stage_sequencer
  import sobel_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 32768,
  parameter int LINE_WORDS      = 64,
  parameter int SLOT_LEN        = 12,
  parameter int PREFETCH_WORD   = 26214,
  parameter int DRAIN_CYCLES    = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              startEn_i,
  input  logic              holdOff_i,
  output logic [ADDR_W-1:0] read_addr_o,
  output logic              popBufferEn_o,
  output logic              sobelShiftEn_o,
  output logic              HoldEn_o,
  output logic              startMultiplierEn_o,
  output logic              startMagEn_o,
  output logic              startDirEn_o,
  output logic              getNext_o,
  output logic              busy_o,
  output logic              frameDone_o
);

`ifdef SOBEL_LINE_SKIP_EN
  localparam int NSLOTS = WORDS_PER_FRAME / 2;
  localparam int LNW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
`else
  localparam int NSLOTS = WORDS_PER_FRAME;
`endif
  localparam int PW = $clog2(SLOT_LEN);
  localparam int WW = 15;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_e        state_q, state_d;
  logic [WW-1:0]     word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              wrap, last_slot;
  logic              pop_q, shift_q, hold_q, mag_q;
`ifdef SOBEL_LINE_SKIP_EN
  logic [LNW-1:0]    line_q, line_d;
`endif

  sobel_slot_timer #(.SLOT_LEN(SLOT_LEN), .PW(PW)) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .run_i     (state_q == RUN),
    .holdOff_i (holdOff_i),
    .phase_o   (phase_q),
    .phase_d_o (phase_d),
    .wrap_o    (wrap)
  );

  assign last_slot = wrap && (word_q == WW'(NSLOTS - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; startEn outside IDLE is simply dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startEn_i) state_d = RUN;
      RUN:     if (last_slot) state_d = DRAIN;
      DRAIN:   if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs; getNext fires on the first unstalled phase-0 cycle
  always_comb begin
    busy_o      = (state_q == RUN) || (state_q == DRAIN);
    frameDone_o = (state_q == DONE);
    getNext_o   = (state_q == RUN) && (phase_q == '0) && !holdOff_i &&
                  (word_q == WW'(PREFETCH_WORD));
  end

  // Word, address and drain counters; all clear whenever not running
  always_comb begin
    word_d  = word_q;
    addr_d  = addr_q;
    drain_d = '0;
`ifdef SOBEL_LINE_SKIP_EN
    line_d  = line_q;
    if (state_d != RUN) begin
      word_d = '0;
      addr_d = '0;
      line_d = '0;
    end else if (wrap) begin
      word_d = word_q + 1'b1;
      // After a full line of issued words, skip over the next line
      if (line_q == LNW'(LINE_WORDS - 1)) begin
        line_d = '0;
        addr_d = addr_q + ADDR_W'(LINE_WORDS + 1);
      end else begin
        line_d = line_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end
`else
    if (state_d != RUN) word_d = '0;
    else if (wrap)      word_d = word_q + 1'b1;
    addr_d = ADDR_W'(word_d);
`endif
    if (state_q == DRAIN && state_d == DRAIN) drain_d = drain_q + 1'b1;
  end

  // Counter registers and stage pulses decoded from the upcoming phase
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      word_q  <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      pop_q   <= 1'b0;
      shift_q <= 1'b0;
      hold_q  <= 1'b0;
      mag_q   <= 1'b0;
`ifdef SOBEL_LINE_SKIP_EN
      line_q  <= '0;
`endif
    end else begin
      word_q  <= word_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      pop_q   <= (state_d == RUN) && (phase_d == PW'(PH_POP));
      shift_q <= (state_d == RUN) && (phase_d == PW'(PH_SHIFT));
      hold_q  <= (state_d == RUN) && (phase_d == PW'(PH_HOLD));
      mag_q   <= (state_d == RUN) && (phase_d == PW'(PH_MAG));
`ifdef SOBEL_LINE_SKIP_EN
      line_q  <= line_d;
`endif
    end
  end

  assign read_addr_o         = addr_q;
  assign popBufferEn_o       = pop_q;
  assign sobelShiftEn_o      = shift_q;
  assign HoldEn_o            = hold_q;
  assign startMultiplierEn_o = hold_q;
  assign startMagEn_o        = mag_q;
  assign startDirEn_o        = mag_q;

endmodule

// File: doc/sobel_stage_sequencer.md
# sobel_stage_sequencer

Sequencer that drives the Sobel datapath stage enables and the input SRAM read address for one frame at a time. It sits between the frame loader, which fills the input SRAM, and the Sobel datapath: buffer, shifter, hold, multiplier, magnitude and direction stages. For every 64-bit input word it issues a fixed pattern of one-cycle stage pulses. It raises an early refill request once most of the frame has been read, and reports frame completion after the pipeline drains.

## Interface
Parameters:
- WORDS_PER_FRAME, 32768: 64-bit input words per frame (512x512 8-bit pixels).
- LINE_WORDS, 64: words per image line.
- SLOT_LEN, 12: cycles per word slot; must be at least 10.
- PREFETCH_WORD, 26214: word index at which getNext fires (4/5 of the frame).
- DRAIN_CYCLES, 16: cycles after the last slot before frameDone.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- reset, in, 1: synchronous, active-low reset (0 = reset).
- startEn, in, 1: start request; sampled only in IDLE.
- holdOff, in, 1: downstream back-pressure; freezes the sequencer at slot start.
- read_addr, out, 20: input SRAM word address.
- popBufferEn, sobelShiftEn, HoldEn, startMultiplierEn, startMagEn, startDirEn, out, 1 each: one-cycle stage pulses.
- getNext, out, 1: one-cycle refill request to the loader.
- busy, out, 1: high in RUN and DRAIN.
- frameDone, out, 1: one-cycle pulse at the end of a frame.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- Transitions:
  - IDLE→RUN when startEn=1.
  - RUN→DRAIN after the last slot's phase SLOT_LEN-1.
  - DRAIN→DONE when the drain counter reaches DRAIN_CYCLES-1.
  - DONE→IDLE unconditionally after 1 cycle.
- Slot counter `phase` (0..SLOT_LEN-1) counts only in RUN. Word counter `word` (15 bits) increments when phase wraps.
- Pulses within a slot (each exactly one cycle, registered):
  - phase 2: popBufferEn.
  - phase 4: sobelShiftEn.
  - phase 6: HoldEn and startMultiplierEn together.
  - phase 8: startMagEn and startDirEn together.
  - All other phases: all stage enables 0.
- read_addr presents the address of `word` from phase 0 of its slot and is held stable for the whole slot. Width is 20 bits, zero-extended from the word address.
- holdOff:
  - Sampled only when phase==0. If 1, phase stays at 0, no pulses are issued, and read_addr holds.
  - holdOff asserted at phase≠0 has no effect until the next slot.
- getNext pulses once per frame, at phase 0 of the first non-stalled cycle of slot PREFETCH_WORD.
- startEn in RUN, DRAIN or DONE is ignored; it is not queued.
- Reset values: state IDLE, phase 0, word 0, read_addr 0, and every pulse output, getNext, busy and frameDone all 0.
- reset=0 mid-frame aborts immediately: all outputs take their reset values the next cycle, and no frameDone is issued.

## Timing
- startEn sampled high in cycle T puts state in RUN at T+1, with read_addr=0 at T+1.
- popBufferEn at T+3, sobelShiftEn at T+5, HoldEn/startMultiplierEn at T+7, startMagEn/startDirEn at T+9.
- Unstalled slot period is SLOT_LEN cycles. A frame without stalls spans N×SLOT_LEN cycles of RUN, then DRAIN_CYCLES of DRAIN, then frameDone in the DONE cycle.
- busy falls in the same cycle frameDone rises.
- Each holdOff-high sample at phase 0 adds exactly one cycle.

## Configuration
- SOBEL_LINE_SKIP_EN defined:
  - The sequencer processes alternate lines only.
  - After every LINE_WORDS issued words, read_addr jumps forward an extra LINE_WORDS.
  - Slot count N = WORDS_PER_FRAME/2.
  - PREFETCH_WORD compares against the issued-slot count, not the address.
- SOBEL_LINE_SKIP_EN undefined: read_addr = word, and N = WORDS_PER_FRAME.

## Structure
- Shared package sobel_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the phase constants PH_POP=2, PH_SHIFT=4, PH_HOLD=6, PH_MAG=8;
  - the address width constant (20).
- One sub-module, sobel_slot_timer: the phase counter with the holdOff freeze and a wrap pulse. The FSM, word and address counters and pulse decode stay in the top level.

## Test plan
- Test parameters: WORDS_PER_FRAME=8, LINE_WORDS=2, PREFETCH_WORD=6, DRAIN_CYCLES=4, SLOT_LEN=12.
- Basic frame: startEn pulse at T → popBufferEn at T+3, T+15, …, 8 times; read_addr steps 0..7; frameDone at T+1+96+4; busy high for 100 cycles.
- Back-pressure: holdOff=1 for 5 cycles at the start of slot 3 → slot 3 pulses shift 5 cycles later; read_addr=3 held throughout; frame end delayed by exactly 5 cycles.
- Prefetch: exactly one getNext, at phase 0 of slot 6; none in slots 0..5 or 7.
- Abort: reset=0 at slot 4 phase 5 → next cycle all outputs 0 and state IDLE; no frameDone; a new startEn restarts at read_addr=0.
- Ignored start: startEn held high through the entire frame → exactly one frame runs, then a second frame starts the cycle after DONE.
- With SOBEL_LINE_SKIP_EN: read_addr sequence is 0, 1, 4, 5; 4 slots; frameDone at T+1+48+4.
